// File: rtl/vblank_update_arbiter_if.sv
// VGA timing stream bundle passed from the timing generator to its consumers.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vblank_update_arbiter.sv
// Round-robin arbiter that confines game-state register updates to vertical blanking.
// Define VBLANK_ARB_TIMEOUT_EN to bound each grant to MAX_GRANT_CYCLES cycles.
module vblank_update_arbiter #(
    parameter int N_REQ            = 4,
    parameter int MAX_GRANT_CYCLES = 1024,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    vga_if.in                vga_in,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             frame_tick,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overrun,
    output logic             busy
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t             r_state;
    logic               r_vblnk_d;
    logic [N_REQ-1:0]   r_served;
    logic [PTR_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_tick;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_overrun;
    logic               r_busy;

    logic               w_vblnk;
    logic               w_rise;
    logic               w_fall;
    logic [N_REQ-1:0]   w_eligible;
    logic               w_found;
    logic [PTR_W-1:0]   w_idx;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_done_hit;
    logic               w_timeout;
    logic               w_unused_vga;

    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    assign w_vblnk      = vga_in.vblnk;
    assign w_unused_vga = ^{vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync, vga_in.hblnk};
    assign w_rise       = w_vblnk & ~r_vblnk_d;
    assign w_fall       = ~w_vblnk & r_vblnk_d;
    assign w_eligible   = req & ~r_served;
    assign w_done_hit   = |(done & r_gnt);

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_eligible[wrapIdx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_idx   = wrapIdx(r_ptr, k);
            end
        end
    end

    assign w_onehot = w_found ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_idx) : '0;

`ifdef VBLANK_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(MAX_GRANT_CYCLES) + 1;

    logic [TCNT_W-1:0] r_tcnt;

    // GRANT is only ever entered from ARB, so clearing outside GRANT restarts it per grant.
    always_ff @(posedge clk) begin
        if (rst || r_state != GRANT) r_tcnt <= '0;
        else                         r_tcnt <= r_tcnt + TCNT_W'(1);
    end

    assign w_timeout = (r_tcnt == TCNT_W'(MAX_GRANT_CYCLES - 1));
`else
    localparam int unused_max_grant_cycles = MAX_GRANT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vblnk_d <= 1'b1;
            r_served  <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_vblnk_d <= w_vblnk;
            r_tick    <= w_rise;
            r_overrun <= 1'b0;
            if (w_rise) begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_served <= '0;
            end
            case (r_state)
                IDLE: begin
                    r_gnt <= '0;
                    if (w_rise) begin
                        r_state <= ARB;
                        r_busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (!w_vblnk || !w_found) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gnt    <= w_onehot;
                        r_served <= (w_rise ? '0 : r_served) | w_onehot;
                        r_ptr    <= wrapIdx(w_idx, 1);
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    // Completion beats a coincident vblank end, so no overrun is reported then.
                    if (w_done_hit) begin
                        r_gnt   <= '0;
                        r_state <= ARB;
                    end else if (w_fall) begin
                        r_gnt     <= '0;
                        r_overrun <= 1'b1;
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                    end else if (w_timeout) begin
                        r_gnt     <= '0;
                        r_overrun <= 1'b1;
                        r_state   <= ARB;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign frame_tick = r_tick;
    assign frame_cnt  = r_cnt;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
